riscv_hart_fetch_sched: RTL and testbench

Per-hart fetch scheduler for the multithreaded RI5CY core. Holds one program counter per hart and picks the next eligible hart round-robin. Issues one instruction-memory request at a time and delivers the returned word, its address and its hart ID to the IF stage through a valid/ready handshake. Sits between the instruction memory port and the IF stage, and applies per-hart PC redirects from the controller.

---
 rtl/riscv_hart_fetch_sched.sv | 180 ++++++++++++++++++
 tb/tb_riscv_hart_fetch_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_hart_fetch_sched.sv
// Per-hart fetch scheduler: one PC per hart, round-robin hart selection, a single
// outstanding instruction-memory request, and a held word offered to the IF stage.
module riscv_hart_fetch_sched #(
    parameter int THREAD_ADDR_WIDTH = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [23:0]                         boot_addr_i,
    input  logic [(2**THREAD_ADDR_WIDTH)-1:0]   hart_en_i,
    input  logic [(2**THREAD_ADDR_WIDTH)-1:0]   hart_stall_i,
    input  logic                                redirect_i,
    input  logic [THREAD_ADDR_WIDTH-1:0]        redirect_hart_i,
    input  logic [31:0]                         redirect_addr_i,
    output logic                                instr_req_o,
    output logic [31:0]                         instr_addr_o,
    input  logic                                instr_gnt_i,
    input  logic                                instr_rvalid_i,
    input  logic [31:0]                         instr_rdata_i,
    output logic                                fetch_valid_o,
    output logic [31:0]                         fetch_data_o,
    output logic [31:0]                         fetch_addr_o,
    output logic [THREAD_ADDR_WIDTH-1:0]        fetch_hart_o,
    input  logic                                fetch_ready_i,
    output logic                                busy_o
);

    localparam int TW     = THREAD_ADDR_WIDTH;
    localparam int N_HART = 2**THREAD_ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q [N_HART];
    logic [31:0]     pc_d [N_HART];
    logic [TW-1:0]   rr_q, rr_d;
    logic [TW-1:0]   sel_q, sel_d;
    logic            kill_q, kill_d;
    logic [31:0]     req_addr_q, req_addr_d;
    logic [31:0]     fdata_q, fdata_d;
    logic [31:0]     faddr_q, faddr_d;
    logic [TW-1:0]   fhart_q, fhart_d;

    logic [N_HART-1:0] elig;
    logic              any_elig;
    logic              found;
    logic [TW-1:0]     winner;
    logic [TW-1:0]     cand;
    logic              redir_sel;
    logic              req_c;
    logic [31:0]       addr_c;

    // A hart being redirected this cycle is skipped so its stale PC is never fetched.
    always_comb begin
        elig = hart_en_i & ~hart_stall_i;
        if (redirect_i) begin
            elig[redirect_hart_i] = 1'b0;
        end
        any_elig = |elig;
        winner   = rr_q;
        cand     = rr_q;
        found    = 1'b0;
        for (int i = 1; i <= N_HART; i++) begin
            cand = rr_q + TW'(i);
            if (!found && elig[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign redir_sel = redirect_i && (redirect_hart_i == sel_q);

    // Memory side: instr_req_o/instr_addr_o are held until instr_gnt_i; one request
    // outstanding. IF side: fetch_valid_o with stable payload until fetch_ready_i.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_d       = rr_q;
        kill_d     = kill_q;
        req_addr_d = req_addr_q;
        fdata_d    = fdata_q;
        faddr_d    = faddr_q;
        fhart_d    = fhart_q;
        req_c      = 1'b0;
        addr_c     = 32'h0;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    req_c      = 1'b1;
                    addr_c     = pc_q[winner];
                    sel_d      = winner;
                    rr_d       = winner;
                    req_addr_d = pc_q[winner];
                    kill_d     = 1'b0;
                    state_d    = instr_gnt_i ? WAIT : REQ;
                end
            end
            REQ: begin
                req_c  = 1'b1;
                addr_c = req_addr_q;
                if (redir_sel) begin
                    kill_d = 1'b1;
                end
                if (instr_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (instr_rvalid_i) begin
                    if (kill_q || redir_sel) begin
                        kill_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        fdata_d = instr_rdata_i;
                        faddr_d = req_addr_q;
                        fhart_d = sel_q;
                        state_d = HOLD;
                    end
                end else if (redir_sel) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redir_sel || fetch_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Redirect is applied last so it overrides the +4 on the same hart.
    always_comb begin
        pc_d = pc_q;
        if (state_q == HOLD && fetch_ready_i && !redir_sel) begin
            pc_d[sel_q] = pc_q[sel_q] + 32'd4;
        end
        if (redirect_i) begin
            pc_d[redirect_hart_i] = {redirect_addr_i[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int h = 0; h < N_HART; h++) begin
                pc_q[h] <= {boot_addr_i, 8'h80};
            end
            state_q    <= IDLE;
            rr_q       <= TW'(N_HART - 1);
            sel_q      <= '0;
            kill_q     <= 1'b0;
            req_addr_q <= 32'h0;
            fdata_q    <= 32'h0;
            faddr_q    <= 32'h0;
            fhart_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            rr_q       <= rr_d;
            sel_q      <= sel_d;
            kill_q     <= kill_d;
            req_addr_q <= req_addr_d;
            fdata_q    <= fdata_d;
            faddr_q    <= faddr_d;
            fhart_q    <= fhart_d;
        end
    end

    // The IDLE request is combinational, so it is masked while reset is held.
    assign instr_req_o   = req_c & rst_n;
    assign instr_addr_o  = instr_req_o ? addr_c : 32'h0;
    assign fetch_valid_o = (state_q == HOLD);
    assign fetch_data_o  = fdata_q;
    assign fetch_addr_o  = faddr_q;
    assign fetch_hart_o  = fhart_q;
    assign busy_o        = (state_q != IDLE);

    gnt_needs_req_a: assert property (@(posedge clk) disable iff (!rst_n) instr_gnt_i |-> instr_req_o);

endmodule

// File: tb/tb_riscv_hart_fetch_sched.sv
// Bench for riscv_hart_fetch_sched: randomized memory/IF/redirect traffic against a
// transaction-level reference model, with directed boot and hart-mask sequences.
module tb_riscv_hart_fetch_sched;

    localparam int TW = 2;
    localparam int NH = 4;
    localparam int EW = TW + 64;

    logic           clk;
    logic           rst_n;
    logic [23:0]    boot_addr_i;
    logic [NH-1:0]  hart_en_i;
    logic [NH-1:0]  hart_stall_i;
    logic           redirect_i;
    logic [TW-1:0]  redirect_hart_i;
    logic [31:0]    redirect_addr_i;
    logic           instr_req_o;
    logic [31:0]    instr_addr_o;
    logic           instr_gnt_i;
    logic           instr_rvalid_i;
    logic [31:0]    instr_rdata_i;
    logic           fetch_valid_o;
    logic [31:0]    fetch_data_o;
    logic [31:0]    fetch_addr_o;
    logic [TW-1:0]  fetch_hart_o;
    logic           fetch_ready_i;
    logic           busy_o;

    riscv_hart_fetch_sched #(.THREAD_ADDR_WIDTH(TW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .boot_addr_i     (boot_addr_i),
        .hart_en_i       (hart_en_i),
        .hart_stall_i    (hart_stall_i),
        .redirect_i      (redirect_i),
        .redirect_hart_i (redirect_hart_i),
        .redirect_addr_i (redirect_addr_i),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .fetch_valid_o   (fetch_valid_o),
        .fetch_data_o    (fetch_data_o),
        .fetch_addr_o    (fetch_addr_o),
        .fetch_hart_o    (fetch_hart_o),
        .fetch_ready_i   (fetch_ready_i),
        .busy_o          (busy_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int n_vec;
    int n_err;
    int n_fetched;
    logic [EW-1:0]   exp_q[$];
    logic [TW+31:0]  iss_log[$];

    // driver knobs
    int            gnt_pct;
    int            rv_max;
    int            ready_pct;
    int            redir_pct;
    int            stall_pct;
    logic          en_rand;
    logic [NH-1:0] en_mask;
    logic          rv_pending;
    int            rv_delay;
    logic [31:0]   rv_addr;

    // reference model state: PCs, last-served hart, in-flight transaction lifecycle
    logic [31:0]   m_pc [NH];
    logic [TW-1:0] m_rr;
    logic [TW-1:0] m_hart;
    logic [31:0]   m_addr;
    logic          m_kill;
    int            m_phase;   // 0 none, 1 awaiting grant, 2 awaiting data, 3 offered to IF

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    always @(negedge clk) begin
        logic [NH-1:0] el;
        int            w;
        logic          hit;
        if (!rst_n) begin
            for (int h = 0; h < NH; h++) m_pc[h] = {boot_addr_i, 8'h80};
            m_rr    = TW'(NH - 1);
            m_phase = 0;
            m_kill  = 1'b0;
            check("rst_req", 96'(instr_req_o), 96'(0));
            check("rst_addr", 96'(instr_addr_o), 96'(0));
            check("rst_busy", 96'(busy_o), 96'(0));
            check("rst_valid", 96'(fetch_valid_o), 96'(0));
            check("rst_fetch_regs", 96'({fetch_hart_o, fetch_addr_o, fetch_data_o}), 96'(0));
        end else begin
            hit = redirect_i && (redirect_hart_i == m_hart);
            check("busy", 96'(busy_o), 96'(m_phase != 0));
            check("fetch_valid", 96'(fetch_valid_o), 96'(m_phase == 3));
            case (m_phase)
                0: begin
                    el = hart_en_i & ~hart_stall_i;
                    if (redirect_i) el[redirect_hart_i] = 1'b0;
                    w = -1;
                    for (int k = 1; k <= NH; k++) begin
                        if (w < 0 && el[(int'(m_rr) + k) % NH]) w = (int'(m_rr) + k) % NH;
                    end
                    if (w < 0) begin
                        check("idle_req", 96'(instr_req_o), 96'(0));
                    end else begin
                        m_hart = TW'(w);
                        m_rr   = TW'(w);
                        m_addr = m_pc[w];
                        m_kill = 1'b0;
                        check("issue_req", 96'(instr_req_o), 96'(1));
                        check("issue_addr", 96'(instr_addr_o), 96'(m_addr));
                        iss_log.push_back({m_hart, m_addr});
                        m_phase = instr_gnt_i ? 2 : 1;
                    end
                end
                1: begin
                    check("req_held", 96'(instr_req_o), 96'(1));
                    check("req_addr_held", 96'(instr_addr_o), 96'(m_addr));
                    if (hit) m_kill = 1'b1;
                    if (instr_gnt_i) m_phase = 2;
                end
                2: begin
                    check("no_req_wait", 96'(instr_req_o), 96'(0));
                    if (hit) m_kill = 1'b1;
                    if (instr_rvalid_i) begin
                        if (m_kill) begin
                            m_phase = 0;
                        end else begin
                            exp_q.push_back({m_hart, m_addr, mem_word(m_addr)});
                            m_phase = 3;
                        end
                    end
                end
                default: begin
                    check("no_req_hold", 96'(instr_req_o), 96'(0));
                    if (hit) begin
                        m_phase = 0;
                    end else if (fetch_ready_i) begin
                        m_pc[m_hart] = m_pc[m_hart] + 32'd4;
                        m_phase = 0;
                    end
                end
            endcase
            if (redirect_i) m_pc[redirect_hart_i] = {redirect_addr_i[31:2], 2'b00};
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (fetch_valid_o) begin
            if (exp_q.size() == 0) begin
                check("fetch_unexpected", 96'(fetch_valid_o), 96'(0));
            end else begin
                check("fetch_word", 96'({fetch_hart_o, fetch_addr_o, fetch_data_o}), 96'(exp_q[0]));
                if (redirect_i && redirect_hart_i == fetch_hart_o) begin
                    void'(exp_q.pop_front());
                end else if (fetch_ready_i) begin
                    void'(exp_q.pop_front());
                    n_fetched++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (en_rand) hart_en_i = ($urandom_range(0, 3) == 0) ? NH'($urandom) : '1;
            else         hart_en_i = en_mask;
            for (int h = 0; h < NH; h++) hart_stall_i[h] = ($urandom_range(0, 99) < stall_pct);
            redirect_i      = ($urandom_range(0, 99) < redir_pct);
            redirect_hart_i = TW'($urandom_range(0, NH - 1));
            redirect_addr_i = $urandom;
            if ($urandom_range(0, 3) == 0) redirect_addr_i = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            fetch_ready_i  = ($urandom_range(0, 99) < ready_pct);
            instr_rvalid_i = 1'b0;
            if (rv_pending) begin
                if (rv_delay <= 1) begin
                    instr_rvalid_i = 1'b1;
                    instr_rdata_i  = mem_word(rv_addr);
                    rv_pending     = 1'b0;
                end else begin
                    rv_delay--;
                end
            end
            #1;
            instr_gnt_i = instr_req_o && ($urandom_range(0, 99) < gnt_pct);
            if (instr_gnt_i) begin
                rv_pending = 1'b1;
                rv_delay   = $urandom_range(1, rv_max);
                rv_addr    = instr_addr_o;
            end
        end
    endtask

    // Asserts reset mid-cycle; a pending response is left to arrive late.
    task automatic do_reset(input logic [23:0] boot, input int cycles);
        @(posedge clk);
        #3;
        rst_n          = 1'b0;
        boot_addr_i    = boot;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        redirect_i     = 1'b0;
        hart_stall_i   = '0;
        hart_en_i      = en_rand ? '1 : en_mask;
        repeat (cycles) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic directed_knobs(input logic [NH-1:0] mask);
        gnt_pct = 100; rv_max = 1; ready_pct = 100; redir_pct = 0; stall_pct = 0;
        en_rand = 1'b0; en_mask = mask;
    endtask

    task automatic random_knobs(input int g, input int r, input int rd, input int s);
        gnt_pct = g; rv_max = 3; ready_pct = r; redir_pct = rd; stall_pct = s; en_rand = 1'b1;
    endtask

    // ---------------- stimulus and directed checks ----------------
    logic [TW+31:0] exp_a [5];
    logic [TW+31:0] exp_b [4];
    int base;

    initial begin
        n_vec = 0; n_err = 0; n_fetched = 0;
        rv_pending = 1'b0; rv_delay = 0; rv_addr = 32'h0;
        rst_n = 1'b0;
        boot_addr_i = 24'h1C0000;
        hart_en_i = '1; hart_stall_i = '0;
        redirect_i = 1'b0; redirect_hart_i = '0; redirect_addr_i = 32'h0;
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
        fetch_ready_i = 1'b1;
        directed_knobs(4'b1111);

        exp_a[0] = {2'd0, 32'h1C00_0080};
        exp_a[1] = {2'd1, 32'h1C00_0080};
        exp_a[2] = {2'd2, 32'h1C00_0080};
        exp_a[3] = {2'd3, 32'h1C00_0080};
        exp_a[4] = {2'd0, 32'h1C00_0084};
        exp_b[0] = {2'd1, 32'h1C00_0080};
        exp_b[1] = {2'd3, 32'h1C00_0080};
        exp_b[2] = {2'd1, 32'h1C00_0084};
        exp_b[3] = {2'd3, 32'h1C00_0084};

        // boot: all harts, immediate memory, IF always ready
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        base = iss_log.size();
        run(24);
        check("boot_issue_count", 96'(iss_log.size() - base >= 5), 96'(1));
        for (int k = 0; k < 5; k++) begin
            if (base + k < iss_log.size()) check("boot_order", 96'(iss_log[base + k]), 96'(exp_a[k]));
        end

        // only harts 1 and 3 enabled
        directed_knobs(4'b1010);
        do_reset(24'h1C0000, 2);
        base = iss_log.size();
        run(24);
        check("mask_issue_count", 96'(iss_log.size() - base >= 4), 96'(1));
        for (int k = 0; k < 4; k++) begin
            if (base + k < iss_log.size()) check("mask_order", 96'(iss_log[base + k]), 96'(exp_b[k]));
        end

        // randomized traffic, with resets landing mid-transaction
        random_knobs(40, 60, 15, 20);
        run(3000);
        do_reset(24'hABCDEF, 2);
        random_knobs(30, 25, 35, 10);
        run(2000);
        do_reset(24'h000001, 1);
        random_knobs(70, 80, 8, 30);
        run(2000);

        // drain with a clean configuration
        directed_knobs(4'b1111);
        run(40);
        check("progress", 96'(n_fetched > 100), 96'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
